// File: rtl/frame_render_sequencer.sv
// rtl/frame_render_sequencer.sv - per-frame layer draw sequencer feeding the LCD draw engine
//
// Walks LAYERS draw descriptors (slot 0 first, bottom-most) once per rising
// edge of frameTick and issues one draw handshake per repetition.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   frameTick           level; rising edge requests one frame
//   abort               ends the frame after the draw in progress
//   clearOverrun        clears the sticky overrun flag (a new overrun wins)
//   layerX/Y/Id/Repeat/Stride  packed per-slot descriptors, slot i at [i*W +: W]
//   drawReady           ready from the draw engine
//   draw, xOrigin, yOrigin, ROMId  draw request and its coordinates
//   busy                high while a frame is being walked
//   frameDone           one-cycle pulse on frame completion or abort
//   overrun             sticky: a tick arrived while a frame was in flight
module frame_render_sequencer #(
  parameter int LAYERS          = 4,
  parameter int X_BITWIDTH      = 8,
  parameter int Y_BITWIDTH      = 9,
  parameter int ID_BITWIDTH     = 4,
  parameter int REPEAT_BITWIDTH = 4,
  parameter int SETTLE_CYCLES   = 20
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                frameTick,
  input  logic                                abort,
  input  logic                                clearOverrun,
  input  logic [LAYERS*X_BITWIDTH-1:0]        layerX,
  input  logic [LAYERS*Y_BITWIDTH-1:0]        layerY,
  input  logic [LAYERS*ID_BITWIDTH-1:0]       layerId,
  input  logic [LAYERS*REPEAT_BITWIDTH-1:0]   layerRepeat,
  input  logic [LAYERS*Y_BITWIDTH-1:0]        layerStride,
  input  logic                                drawReady,
  output logic                                draw,
  output logic [X_BITWIDTH-1:0]               xOrigin,
  output logic [Y_BITWIDTH-1:0]               yOrigin,
  output logic [ID_BITWIDTH-1:0]              ROMId,
  output logic                                busy,
  output logic                                frameDone,
  output logic                                overrun
);

  localparam int LAYER_W = $clog2(LAYERS + 1);
  localparam int SLOT_W  = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CNT_W   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PROD_W  = Y_BITWIDTH + REPEAT_BITWIDTH;

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, GAP, DONE} stateType;

  stateType state, nextState;

  logic                       tickHold;
  logic                       tickRise;
  logic [LAYER_W-1:0]         layer;
  logic [REPEAT_BITWIDTH-1:0] rep;
  logic [CNT_W-1:0]           settleCount;

  logic [X_BITWIDTH-1:0]      snapX      [LAYERS];
  logic [Y_BITWIDTH-1:0]      snapY      [LAYERS];
  logic [ID_BITWIDTH-1:0]     snapId     [LAYERS];
  logic [REPEAT_BITWIDTH-1:0] snapRepeat [LAYERS];
  logic [Y_BITWIDTH-1:0]      snapStride [LAYERS];

  logic [SLOT_W-1:0]          slot;
  logic [REPEAT_BITWIDTH-1:0] curRepeat;
  logic                       atEnd;
  logic                       settled;
  logic                       lastRep;
  logic [PROD_W-1:0]          strideProduct;
  logic [PROD_W-1:0]          ySum;

  assign tickRise = frameTick && !tickHold;

  // layer reaches LAYERS only as the end marker; slot is never used to read
  // the snapshot in that case because atEnd is checked first.
  assign slot      = layer[SLOT_W-1:0];
  assign curRepeat = snapRepeat[slot];
  assign atEnd     = (layer == LAYER_W'(LAYERS));
  assign settled   = (settleCount >= CNT_W'(SETTLE_CYCLES));
  assign lastRep   = ({1'b0, rep} + 1'b1) == {1'b0, curRepeat};

  assign strideProduct = {{REPEAT_BITWIDTH{1'b0}}, snapStride[slot]} * {{Y_BITWIDTH{1'b0}}, rep};
  assign ySum          = {{REPEAT_BITWIDTH{1'b0}}, snapY[slot]} + strideProduct;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (tickRise) nextState = SELECT;
      SELECT: begin
        if (abort || atEnd)      nextState = DONE;
        else if (curRepeat == 0) nextState = SELECT;
        else                     nextState = ISSUE;
      end
      ISSUE:  if (settled && drawReady) nextState = GAP;
      GAP:    nextState = abort ? DONE : SELECT;
      DONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state so that reset drops draw immediately
  always_comb begin
    draw      = (state == ISSUE);
    busy      = (state == SELECT) || (state == ISSUE) || (state == GAP);
    frameDone = (state == DONE);
  end

  // Datapath: snapshot, walk counters, settle counter, coordinates, overrun
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tickHold    <= 1'b0;
      overrun     <= 1'b0;
      layer       <= '0;
      rep         <= '0;
      settleCount <= '0;
      xOrigin     <= '0;
      yOrigin     <= '0;
      ROMId       <= '0;
      for (int i = 0; i < LAYERS; i++) begin
        snapX[i]      <= '0;
        snapY[i]      <= '0;
        snapId[i]     <= '0;
        snapRepeat[i] <= '0;
        snapStride[i] <= '0;
      end
    end else begin
      tickHold <= frameTick;

      // A tick outside IDLE is discarded but remembered; setting beats clearing.
      if (tickRise && state != IDLE) overrun <= 1'b1;
      else if (clearOverrun)         overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (tickRise) begin
            layer       <= '0;
            rep         <= '0;
            settleCount <= '0;
            for (int i = 0; i < LAYERS; i++) begin
              snapX[i]      <= layerX[i*X_BITWIDTH +: X_BITWIDTH];
              snapY[i]      <= layerY[i*Y_BITWIDTH +: Y_BITWIDTH];
              snapId[i]     <= layerId[i*ID_BITWIDTH +: ID_BITWIDTH];
              snapRepeat[i] <= layerRepeat[i*REPEAT_BITWIDTH +: REPEAT_BITWIDTH];
              snapStride[i] <= layerStride[i*Y_BITWIDTH +: Y_BITWIDTH];
            end
          end
        end
        SELECT: begin
          if (!abort && !atEnd) begin
            if (curRepeat == 0) begin
              layer <= layer + LAYER_W'(1);
            end else begin
              xOrigin     <= snapX[slot];
              yOrigin     <= ySum[Y_BITWIDTH-1:0];
              ROMId       <= snapId[slot];
              settleCount <= '0;
            end
          end
        end
        ISSUE: begin
          // Saturating so a stalled draw engine cannot wrap the counter.
          if (settled && drawReady) settleCount <= '0;
          else if (!settled)        settleCount <= settleCount + CNT_W'(1);
        end
        GAP: begin
          if (lastRep) begin
            rep   <= '0;
            layer <= layer + LAYER_W'(1);
          end else begin
            rep <= rep + REPEAT_BITWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_render_sequencer.sv
// tb/tb_frame_render_sequencer.sv - self-checking bench for frame_render_sequencer
module tb_frame_render_sequencer;

  localparam int LAYERS = 4;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int IW = 4;
  localparam int RW = 4;
  localparam int SETTLE = 20;

  logic clock;
  logic reset_n;
  logic frameTick, abort, clearOverrun, drawReady;
  logic [LAYERS*XW-1:0] layerX;
  logic [LAYERS*YW-1:0] layerY;
  logic [LAYERS*IW-1:0] layerId;
  logic [LAYERS*RW-1:0] layerRepeat;
  logic [LAYERS*YW-1:0] layerStride;
  logic draw, busy, frameDone, overrun;
  logic [XW-1:0] xOrigin;
  logic [YW-1:0] yOrigin;
  logic [IW-1:0] ROMId;

  frame_render_sequencer #(
    .LAYERS(LAYERS), .X_BITWIDTH(XW), .Y_BITWIDTH(YW), .ID_BITWIDTH(IW),
    .REPEAT_BITWIDTH(RW), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .frameTick(frameTick), .abort(abort),
    .clearOverrun(clearOverrun), .layerX(layerX), .layerY(layerY), .layerId(layerId),
    .layerRepeat(layerRepeat), .layerStride(layerStride), .drawReady(drawReady),
    .draw(draw), .xOrigin(xOrigin), .yOrigin(yOrigin), .ROMId(ROMId),
    .busy(busy), .frameDone(frameDone), .overrun(overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int x;
    int y;
    int id;
  } drawRec;

  drawRec expQ[$];
  drawRec obsLog[$];
  int     lenLog[$];
  int     passCount = 0;
  int     checkCount = 0;
  int     doneCount = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: the draws a frame must produce, from the descriptors as they stand now.
  task automatic pushModel();
    for (int l = 0; l < LAYERS; l++) begin
      int n, bx, by, bi, bs;
      n  = int'(layerRepeat[l*RW +: RW]);
      bx = int'(layerX[l*XW +: XW]);
      by = int'(layerY[l*YW +: YW]);
      bi = int'(layerId[l*IW +: IW]);
      bs = int'(layerStride[l*YW +: YW]);
      for (int r = 0; r < n; r++) begin
        drawRec d;
        d.x  = bx;
        d.y  = (by + bs * r) % (1 << YW);
        d.id = bi;
        expQ.push_back(d);
      end
    end
  endtask

  task automatic setSlot(input int i, input int x, input int y, input int id,
                         input int rp, input int st);
    layerX[i*XW +: XW]      = XW'(x);
    layerY[i*YW +: YW]      = YW'(y);
    layerId[i*IW +: IW]     = IW'(id);
    layerRepeat[i*RW +: RW] = RW'(rp);
    layerStride[i*YW +: YW] = YW'(st);
  endtask

  task automatic clearSlots();
    for (int i = 0; i < LAYERS; i++) setSlot(i, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    frameTick = 1'b1;
    step();
    step();
    frameTick = 1'b0;
    step();
  endtask

  task automatic waitDone(input string name, input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 2000) begin
      step();
      n++;
    end
    check(name, longint'(doneCount >= target), 1);
  endtask

  task automatic waitDraw(input string name, input logic level);
    int n;
    n = 0;
    while (draw !== level && n < 500) begin
      step();
      n++;
    end
    check(name, longint'(draw), longint'(level));
  endtask

  task automatic startTest();
    expQ.delete();
    obsLog.delete();
    lenLog.delete();
  endtask

  // Compare process: every draw against the model, plus handshake rules.
  initial begin
    logic prevDraw, lastReady;
    int drawLen;
    drawRec hold;
    prevDraw = 1'b0;
    lastReady = 1'b0;
    drawLen = 0;
    hold = '{0, 0, 0};
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevDraw = 1'b0;
        drawLen = 0;
      end else begin
        if (frameDone) doneCount++;
        if (draw && !prevDraw) begin
          hold.x = int'(xOrigin);
          hold.y = int'(yOrigin);
          hold.id = int'(ROMId);
          obsLog.push_back(hold);
          drawLen = 1;
          if (expQ.size() == 0) begin
            check("unexpected draw", 1, 0);
          end else begin
            drawRec e;
            e = expQ.pop_front();
            check("draw xOrigin", hold.x, e.x);
            check("draw yOrigin", hold.y, e.y);
            check("draw ROMId", hold.id, e.id);
          end
          check("busy during draw", longint'(busy), 1);
        end else if (draw) begin
          drawLen++;
          check("origin stable", {xOrigin, yOrigin, ROMId}, {XW'(hold.x), YW'(hold.y), IW'(hold.id)});
        end else if (prevDraw) begin
          check("draw held >= settle+1", longint'(drawLen >= SETTLE + 1), 1);
          check("drawReady at drop", longint'(lastReady), 1);
          lenLog.push_back(drawLen);
        end
        prevDraw = draw;
        lastReady = drawReady;
      end
    end
  end

  initial begin
    int startDone;
    reset_n = 1'b0;
    frameTick = 1'b0;
    abort = 1'b0;
    clearOverrun = 1'b0;
    drawReady = 1'b1;
    clearSlots();

    // 1: reset with random inputs and ticks
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      frameTick = $urandom_range(0, 1);
      abort = $urandom_range(0, 1);
      clearOverrun = $urandom_range(0, 1);
      drawReady = $urandom_range(0, 1);
      layerX = $urandom;
      layerRepeat = $urandom;
    end
    #2;
    check("reset draw", longint'(draw), 0);
    check("reset busy", longint'(busy), 0);
    check("reset frameDone", longint'(frameDone), 0);
    check("reset overrun", longint'(overrun), 0);
    check("reset xOrigin", longint'(xOrigin), 0);
    check("reset yOrigin", longint'(yOrigin), 0);
    check("reset ROMId", longint'(ROMId), 0);
    frameTick = 1'b0;
    abort = 1'b0;
    clearOverrun = 1'b0;
    drawReady = 1'b1;
    clearSlots();
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("idle after reset busy", longint'(busy), 0);
    check("idle after reset done", longint'(doneCount), 0);

    // 2: basic two-layer frame
    startTest();
    setSlot(0, 239, 100, 11, 1, 0);
    setSlot(1, 31, 100, 5, 3, 32);
    startDone = doneCount;
    pushModel();
    tick();
    waitDone("t2 frameDone", startDone + 1);
    repeat (20) step();
    check("t2 single frameDone", longint'(doneCount), longint'(startDone + 1));
    check("t2 busy after", longint'(busy), 0);
    check("t2 model drained", longint'(expQ.size()), 0);
    check("t2 draw count", longint'(obsLog.size()), 4);
    if (obsLog.size() == 4 && lenLog.size() == 4) begin
      check("t2 d0 x", obsLog[0].x, 239);
      check("t2 d0 y", obsLog[0].y, 100);
      check("t2 d0 id", obsLog[0].id, 11);
      check("t2 d1 y", obsLog[1].y, 100);
      check("t2 d2 y", obsLog[2].y, 132);
      check("t2 d3 x", obsLog[3].x, 31);
      check("t2 d3 y", obsLog[3].y, 164);
      check("t2 d3 id", obsLog[3].id, 5);
      for (int i = 0; i < 4; i++) check("t2 draw length", lenLog[i], 21);
    end

    // 3: Y wrap
    startTest();
    clearSlots();
    setSlot(0, 7, 500, 3, 2, 32);
    startDone = doneCount;
    pushModel();
    tick();
    waitDone("t3 frameDone", startDone + 1);
    check("t3 draw count", longint'(obsLog.size()), 2);
    if (obsLog.size() == 2) begin
      check("t3 y0", obsLog[0].y, 500);
      check("t3 y1 wrapped", obsLog[1].y, 20);
    end

    // 4: overrun while busy, clear loses to a simultaneous tick
    startTest();
    clearSlots();
    setSlot(0, 1, 10, 1, 1, 0);
    setSlot(2, 2, 20, 2, 2, 5);
    startDone = doneCount;
    pushModel();
    tick();
    repeat (10) step();
    frameTick = 1'b1;
    step();
    step();
    check("t4 overrun set", longint'(overrun), 1);
    frameTick = 1'b0;
    step();
    frameTick = 1'b1;
    clearOverrun = 1'b1;
    step();
    clearOverrun = 1'b0;
    step();
    check("t4 set beats clear", longint'(overrun), 1);
    check("t4 still busy", longint'(busy), 1);
    waitDone("t4 frameDone", startDone + 1);
    repeat (40) step();
    check("t4 no extra frame", longint'(doneCount), longint'(startDone + 1));
    check("t4 model drained", longint'(expQ.size()), 0);
    frameTick = 1'b0;
    clearOverrun = 1'b1;
    step();
    clearOverrun = 1'b0;
    step();
    check("t4 overrun cleared", longint'(overrun), 0);

    // 5: snapshot isolation and a stalled draw engine
    startTest();
    clearSlots();
    setSlot(0, 10, 50, 2, 3, 7);
    startDone = doneCount;
    pushModel();
    tick();
    waitDraw("t5 draw1 rise", 1'b1);
    setSlot(0, 99, 300, 9, 3, 1);
    waitDraw("t5 draw1 fall", 1'b0);
    drawReady = 1'b0;
    waitDraw("t5 draw2 rise", 1'b1);
    repeat (100) step();
    check("t5 draw held while not ready", longint'(draw), 1);
    drawReady = 1'b1;
    step();
    check("t5 drop one cycle after ready", longint'(draw), 0);
    waitDone("t5 frameDone", startDone + 1);
    check("t5 model drained", longint'(expQ.size()), 0);
    if (obsLog.size() == 3) check("t5 snapshot y2", obsLog[2].y, 64);

    // 6a: abort during the 2nd of 3 draws
    startTest();
    clearSlots();
    setSlot(0, 4, 40, 6, 3, 10);
    startDone = doneCount;
    expQ.push_back('{4, 40, 6});
    expQ.push_back('{4, 50, 6});
    tick();
    waitDraw("t6 draw1 rise", 1'b1);
    waitDraw("t6 draw1 fall", 1'b0);
    waitDraw("t6 draw2 rise", 1'b1);
    repeat (5) step();
    abort = 1'b1;
    step();
    check("t6 draw not truncated", longint'(draw), 1);
    waitDone("t6 frameDone", startDone + 1);
    abort = 1'b0;
    repeat (40) step();
    check("t6 draws before abort", longint'(obsLog.size()), 2);
    check("t6 busy after abort", longint'(busy), 0);

    // 6b: reset mid-draw loses the frame
    startTest();
    clearSlots();
    setSlot(3, 8, 8, 8, 2, 8);
    startDone = doneCount;
    pushModel();
    tick();
    waitDraw("t6 reset draw rise", 1'b1);
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async draw drop", longint'(draw), 0);
    check("t6 async busy drop", longint'(busy), 0);
    step();
    reset_n = 1'b1;
    expQ.delete();
    repeat (50) step();
    check("t6 no frameDone after reset", longint'(doneCount), longint'(startDone));
    check("t6 idle after reset", longint'(draw), 0);

    // all-zero repeats: frame completes with no draw
    startTest();
    clearSlots();
    startDone = doneCount;
    tick();
    waitDone("zero frameDone", startDone + 1);
    check("zero no draws", longint'(obsLog.size()), 0);
    check("zero busy after", longint'(busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
